// File: rtl/uart_baud_gen.sv
// Fractional-divisor UART baud generator: oversample, mid-bit and end-of-bit ticks.
// The divisor is shadowed so that a write never disturbs the period already in progress.
module uart_baud_gen #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int SC_W = $clog2(OSR);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OSR - 1);
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OSR / 2 - 1);

  logic [DIV_W:0]    r_pc;
  logic [FRAC_W-1:0] r_fa;
  logic              r_cp;
  logic [SC_W-1:0]   r_sc;
  logic [DIV_W-1:0]  r_sdi;
  logic [FRAC_W-1:0] r_sdf;
  logic              r_os;
  logic              r_mid;
  logic              r_bit;

  logic [DIV_W-1:0]  w_ei;
  logic [DIV_W:0]    w_tc;
  logic              w_term;
  logic [FRAC_W:0]   w_sum;
  logic              w_load;

  // A zero divisor behaves like one so the generator never stalls.
  assign w_ei   = (r_sdi == '0) ? DIV_W'(1) : r_sdi;
  // A pending fractional carry stretches this period by one clock.
  assign w_tc   = {1'b0, w_ei} - (DIV_W + 1)'(1) + {{DIV_W{1'b0}}, r_cp};
  assign w_term = (r_pc == w_tc);
  assign w_sum  = {1'b0, r_fa} + {1'b0, r_sdf};
  assign w_load = restart | ~enable | w_term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= '0;
      r_fa  <= '0;
      r_cp  <= 1'b0;
      r_sc  <= '0;
      r_sdi <= '0;
      r_sdf <= '0;
      r_os  <= 1'b0;
      r_mid <= 1'b0;
      r_bit <= 1'b0;
    end else begin
      r_os  <= 1'b0;
      r_mid <= 1'b0;
      r_bit <= 1'b0;
      if (restart) begin
        r_pc <= '0;
        r_fa <= '0;
        r_cp <= 1'b0;
        r_sc <= '0;
      end else if (enable) begin
        if (w_term) begin
          r_pc  <= '0;
          r_os  <= 1'b1;
          r_fa  <= w_sum[FRAC_W-1:0];
          r_cp  <= w_sum[FRAC_W];
          r_sc  <= (r_sc == SC_LAST) ? '0 : r_sc + SC_W'(1);
          r_mid <= (r_sc == SC_MID);
          r_bit <= (r_sc == SC_LAST);
        end else begin
          r_pc <= r_pc + (DIV_W + 1)'(1);
        end
      end
      if (w_load) begin
        r_sdi <= div_int;
        r_sdf <= div_frac;
      end
    end
  end

  assign os_tick  = r_os;
  assign mid_tick = r_mid;
  assign bit_tick = r_bit;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed timing scenarios plus a random run, all checked
// cycle by cycle against a period-length reference model.
module tb_uart_baud_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              restart;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;

  uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .restart  (restart),
    .div_int  (div_int),
    .div_frac (div_frac),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: clocks elapsed in the current period, accumulated fraction,
  // pending carry, and oversample ticks counted since the last phase clear.
  int m_el, m_acc, m_carry, m_ntick, m_sdi, m_sdf;
  bit e_os, e_mid, e_bit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_el = 0; m_acc = 0; m_carry = 0; m_ntick = 0; m_sdi = 0; m_sdf = 0;
    e_os = 0; e_mid = 0; e_bit = 0;
  endtask

  task automatic model_clock(input bit en, input bit rs, input int di, input int df);
    int period;
    int s;
    e_os = 0; e_mid = 0; e_bit = 0;
    if (rs) begin
      m_el = 0; m_acc = 0; m_carry = 0; m_ntick = 0;
      m_sdi = di; m_sdf = df;
    end else if (!en) begin
      m_sdi = di; m_sdf = df;
    end else begin
      period = ((m_sdi == 0) ? 1 : m_sdi) + m_carry;
      if (m_el + 1 == period) begin
        m_el    = 0;
        e_os    = 1;
        m_ntick = (m_ntick + 1) % OSR;
        e_mid   = (m_ntick == OSR / 2);
        e_bit   = (m_ntick == 0);
        s       = m_acc + m_sdf;
        m_carry = s / (1 << FRAC_W);
        m_acc   = s % (1 << FRAC_W);
        m_sdi   = di; m_sdf = df;
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock(enable, restart, int'(div_int), int'(div_frac));
    cyc++;
    #1;
    chk("os_tick", 32'(os_tick), 32'(e_os));
    chk("mid_tick", 32'(mid_tick), 32'(e_mid));
    chk("bit_tick", 32'(bit_tick), 32'(e_bit));
  endtask

  // sel: 0 = os_tick, 1 = mid_tick, 2 = bit_tick
  task automatic wait_for(input int sel, input int limit, input string tag, output int dt);
    dt = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if ((sel == 0 && os_tick) || (sel == 1 && mid_tick) || (sel == 2 && bit_tick)) begin
        dt = i;
        break;
      end
    end
    if (dt < 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: no tick within %0d cycles, expected one", tag, limit);
    end
  endtask

  task automatic pulse_restart(input string tag);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk(tag, {29'd0, os_tick, mid_tick, bit_tick}, 32'd0);
  endtask

  initial begin
    int dt, s0, t0, k, cnt;
    bit ok;
    reset = 1'b1; enable = 1'b0; restart = 1'b0;
    div_int = 16'd4; div_frac = 4'd0;
    model_reset();
    #12;
    chk("reset_outputs", {29'd0, os_tick, mid_tick, bit_tick}, 32'd0);
    reset = 1'b0;

    // 1: divisor 4, x16 oversampling
    step();
    enable = 1'b1;
    s0 = cyc;
    wait_for(0, 20, "t1_first_os", dt);
    chk("t1_first_os", 32'(dt), 32'd4);
    wait_for(1, 100, "t1_mid", dt);
    chk("t1_mid_at", 32'(cyc - s0), 32'd32);
    wait_for(2, 100, "t1_bit", dt);
    chk("t1_bit_at", 32'(cyc - s0), 32'd64);
    wait_for(2, 100, "t1_bit2", dt);
    chk("t1_bit_period", 32'(dt), 32'd64);
    wait_for(0, 20, "t1_os", dt);
    chk("t1_os_period", 32'(dt), 32'd4);

    // 2: 27 + 2/16, one long period in every eight
    div_int = 16'd27; div_frac = 4'd2;
    pulse_restart("t2_restart_quiet");
    wait_for(0, 40, "t2_os", dt);
    t0 = cyc;
    for (int i = 0; i < 8; i++) wait_for(0, 40, "t2_os", dt);
    chk("t2_8_periods", 32'(cyc - t0), 32'd217);
    wait_for(2, 600, "t2_bit", dt);
    t0 = cyc;
    for (int i = 0; i < 16; i++) wait_for(2, 600, "t2_bit", dt);
    ok = ((cyc - t0) >= 6944 - 28) && ((cyc - t0) <= 6944 + 28);
    chk("t2_16_bits_span", 32'(ok), 32'd1);

    // 3: divisor change mid-period does not affect the running period
    div_int = 16'd10; div_frac = 4'd0;
    pulse_restart("t3_restart_quiet");
    wait_for(0, 20, "t3_os", dt);
    t0 = cyc;
    for (int i = 0; i < 5; i++) step();
    div_int = 16'd3;
    wait_for(0, 20, "t3_os", dt);
    chk("t3_current_period", 32'(cyc - t0), 32'd10);
    wait_for(0, 20, "t3_os", dt);
    chk("t3_new_period", 32'(dt), 32'd3);
    wait_for(0, 20, "t3_os", dt);
    chk("t3_new_period2", 32'(dt), 32'd3);

    // 4: restart mid-bit, landing on a terminal count
    div_int = 16'd4;
    pulse_restart("t4_restart_quiet");
    for (int i = 0; i < 9; i++) wait_for(0, 20, "t4_os", dt);
    for (int i = 0; i < 3; i++) step();
    pulse_restart("t4_restart_at_tc");
    s0 = cyc;
    wait_for(0, 20, "t4_os", dt);
    chk("t4_first_os", 32'(dt), 32'd4);
    wait_for(1, 100, "t4_mid", dt);
    chk("t4_mid_at", 32'(cyc - s0), 32'd32);
    wait_for(2, 100, "t4_bit", dt);
    chk("t4_bit_at", 32'(cyc - s0), 32'd64);

    // 5: enable gap holds phase; restart while disabled clears it
    pulse_restart("t5_restart_quiet");
    for (int i = 0; i < 3; i++) wait_for(0, 20, "t5_os", dt);
    for (int i = 0; i < 2; i++) step();
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      cnt += int'(os_tick) + int'(mid_tick) + int'(bit_tick);
    end
    chk("t5_gap_ticks", 32'(cnt), 32'd0);
    enable = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      wait_for(0, 20, "t5_os", dt);
      k++;
      if (mid_tick) break;
    end
    chk("t5_ticks_to_mid", 32'(k), 32'd5);
    enable = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int i = 0; i < 5; i++) step();
    enable = 1'b1;
    s0 = cyc;
    wait_for(1, 100, "t5_mid", dt);
    chk("t5_mid_after_restart", 32'(cyc - s0), 32'd32);

    // 6: zero integer divisor with half-clock fraction
    div_int = 16'd0; div_frac = 4'd8;
    pulse_restart("t6_restart_quiet");
    for (int i = 0; i < 2; i++) wait_for(0, 5, "t6_os", dt);
    for (int i = 0; i < 4; i++) begin
      wait_for(0, 5, "t6_os", dt);
      chk("t6_period", 32'(dt), (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_reset", {29'd0, os_tick, mid_tick, bit_tick}, 32'd0);
    model_reset();
    #3;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // random run; the divisor only changes together with a restart
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        restart  = 1'b1;
        div_int  = 16'($urandom_range(0, 7));
        div_frac = 4'($urandom_range(0, 15));
      end else begin
        restart = 1'b0;
      end
      enable = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
